// File: rtl/divider_seq_pkg.sv
// Shared types and constants for the sequential DIV/DIVU unit.
package divider_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  localparam int DIV_DATA_W = 32;

  function automatic int div_count_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DIV_COUNT_W = div_count_w(DIV_DATA_W);

  // Quotient reported for a zero divisor.
  localparam logic [DIV_DATA_W-1:0] DIV_DBZ_QUOT = '1;

endpackage

// File: rtl/divider_seq_opext.sv
// Operand extender: DATA_WIDTH -> DATA_WIDTH+1, sign- or zero-extended.
module div_opext #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_is_signed,
  input  logic [DATA_WIDTH-1:0] i_op,
  output logic [DATA_WIDTH:0]   o_ext
);

  assign o_ext = {i_is_signed & i_op[DATA_WIDTH-1], i_op};

endmodule

// File: rtl/divider_seq.sv
// Sequential restoring divider for DIV/DIVU: one quotient bit per cycle,
// sign fix-up in a final cycle, one-cycle done pulse.
module divider_seq
  import divider_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_is_signed,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_quotient,
  output logic [DATA_WIDTH-1:0] o_remainder,
  output logic                  o_div_by_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = div_count_w(DATA_WIDTH);

  state_e          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_quo, r_rem;
  logic [W:0]      r_dvs;
  logic            r_sa, r_sb, r_dbz_pend;
  logic [W-1:0]    r_q, r_r;
  logic            r_dbz, r_done;

  logic [W:0]      w_a_ext, w_b_ext;
  logic [W-1:0]    w_a_mag, w_b_mag;
  logic            w_b_zero, w_accept, w_busy, w_fix_fire;
  logic [W:0]      w_sh;
  logic [W-1:0]    w_diff, w_q_fix, w_r_fix;
  logic            w_ok;

  div_opext #(.DATA_WIDTH(W)) u_ext_a (
    .i_is_signed(i_is_signed), .i_op(i_dividend), .o_ext(w_a_ext));
  div_opext #(.DATA_WIDTH(W)) u_ext_b (
    .i_is_signed(i_is_signed), .i_op(i_divisor),  .o_ext(w_b_ext));

  // Magnitudes always fit W bits (|MIN| = 2^(W-1)), so W-bit negation is exact.
  assign w_a_mag  = w_a_ext[W] ? -w_a_ext[W-1:0] : w_a_ext[W-1:0];
  assign w_b_mag  = w_b_ext[W] ? -w_b_ext[W-1:0] : w_b_ext[W-1:0];
  assign w_b_zero = (i_divisor == '0);

  // Restoring step; on success the true difference is < divisor, so W bits suffice.
  assign w_sh   = {r_rem, r_quo[W-1]};
  assign w_ok   = (w_sh >= r_dvs);
  assign w_diff = w_sh[W-1:0] - r_dvs[W-1:0];

  assign w_q_fix = (r_sa ^ r_sb) ? -r_quo : r_quo;
  assign w_r_fix = r_sa ? -r_rem : r_rem;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_flush) w_next = S_IDLE;
    else begin
      case (r_state)
        S_IDLE:  if (i_start) w_next = w_b_zero ? S_FIX : S_RUN;
        S_RUN:   if (r_cnt == CW'(1)) w_next = S_FIX;
        S_FIX:   w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_busy     = (r_state != S_IDLE);
    w_accept   = (r_state == S_IDLE) && i_start && !i_flush;
    w_fix_fire = (r_state == S_FIX) && !i_flush;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0; r_quo <= '0; r_rem <= '0; r_dvs <= '0;
      r_sa <= 1'b0; r_sb <= 1'b0; r_dbz_pend <= 1'b0;
      r_q <= '0; r_r <= '0; r_dbz <= 1'b0; r_done <= 1'b0;
    end else begin
      r_done <= w_fix_fire;
      if (w_accept) begin
        r_sa       <= w_a_ext[W];
        r_sb       <= w_b_ext[W];
        r_dvs      <= {1'b0, w_b_mag};
        r_rem      <= '0;
        r_cnt      <= CW'(W);
        r_dbz_pend <= w_b_zero;
        // Zero divisor: keep the raw dividend so it can be returned untouched.
        r_quo      <= w_b_zero ? w_a_ext[W-1:0] : w_a_mag;
      end else if (r_state == S_RUN) begin
        r_rem <= w_ok ? w_diff : w_sh[W-1:0];
        r_quo <= {r_quo[W-2:0], w_ok};
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_fix_fire) begin
        r_dbz <= r_dbz_pend;
        r_q   <= r_dbz_pend ? {W{1'b1}} : w_q_fix;
        r_r   <= r_dbz_pend ? r_quo     : w_r_fix;
      end
    end
  end

  assign o_busy        = w_busy;
  assign o_done        = r_done;
  assign o_quotient    = r_q;
  assign o_remainder   = r_r;
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_seq.sv
// Randomized + directed bench for divider_seq against an arithmetic reference.
module tb_divider_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, is_signed = 1'b0, flush = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic        busy, done, dbz;
  logic [31:0] quotient, remainder;

  int total = 0;
  int bad   = 0;
  logic [31:0] pq = '0, pr = '0;
  logic        pdbz = 1'b0;

  divider_seq #(.DATA_WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_is_signed(is_signed),
    .i_flush(flush), .i_dividend(dividend), .i_divisor(divisor),
    .o_busy(busy), .o_done(done), .o_quotient(quotient),
    .o_remainder(remainder), .o_div_by_zero(dbz));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb, lq, lr;
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      lq = sa / sb; lr = sa % sb;
      q = lq[31:0]; r = lr[31:0]; z = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  // Called at a negedge; that cycle is cycle 0 of the request.
  task automatic run_op(input string nm, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input int flush_at, input int poke_at);
    logic [31:0] eq, er;
    logic ez;
    int lat, done_at, busy_n;
    model(s, a, b, eq, er, ez);
    lat = (b == 0) ? 2 : 34;
    done_at = -1; busy_n = 0;
    is_signed = s; dividend = a; divisor = b; start = 1'b1;
    for (int c = 1; c <= 60 && done_at < 0; c++) begin
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      if (c == poke_at) begin
        start = 1'b1; dividend = 32'h0000_1234; divisor = 32'h0000_0003;
      end
      if (c == flush_at) flush = 1'b1;
      if (busy) busy_n++;
      if (done) begin
        done_at = c;
        chk({nm, ".busy_at_done"}, 64'(busy), 64'd0);
      end
    end
    if (flush_at > 0) begin
      chk({nm, ".no_done"},   64'(done_at), 64'(-1));
      chk({nm, ".busy_cyc"},  64'(busy_n),  64'(flush_at));
      chk({nm, ".q_held"},    64'(quotient),  64'(pq));
      chk({nm, ".r_held"},    64'(remainder), 64'(pr));
      chk({nm, ".dbz_held"},  64'(dbz),       64'(pdbz));
    end else begin
      chk({nm, ".done_cyc"},  64'(done_at), 64'(lat));
      chk({nm, ".busy_cyc"},  64'(busy_n),  64'(lat - 1));
      chk({nm, ".q"},         64'(quotient),  64'(eq));
      chk({nm, ".r"},         64'(remainder), 64'(er));
      chk({nm, ".dbz"},       64'(dbz),       64'(ez));
      pq = eq; pr = er; pdbz = ez;
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.q",    64'(quotient), 64'd0);
    chk("rst.r",    64'(remainder), 64'd0);
    chk("rst.dbz",  64'(dbz), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("divu_100_7",  1'b0, 32'd100, 32'd7, -1, -1);
    run_op("div_m7_2",    1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1);
    run_op("divu_m7_2",   1'b0, 32'hFFFF_FFF9, 32'd2, -1, -1);
    run_op("div_min_m1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    run_op("divu_min_2",  1'b0, 32'h8000_0000, 32'd2, -1, -1);
    run_op("divu_5_0",    1'b0, 32'd5, 32'd0, -1, -1);
    run_op("div_9_3",     1'b1, 32'd9, 32'd3, -1, -1);
    run_op("div_m5_0",    1'b1, 32'hFFFF_FFFB, 32'd0, -1, -1);
    run_op("div_m9_m4",   1'b1, 32'hFFFF_FFF7, 32'hFFFF_FFFC, -1, -1);

    @(negedge clk);
    run_op("flush",       1'b0, 32'd100, 32'd7, 10, -1);
    run_op("poke",        1'b0, 32'd100, 32'd7, -1, 5);
    repeat (3) @(negedge clk);
    chk("poke.idle_busy", 64'(busy), 64'd0);
    chk("poke.idle_done", 64'(done), 64'd0);

    // Back-to-back: second request issued in the done cycle of the first.
    run_op("b2b_a",       1'b1, 32'd1000, 32'hFFFF_FFF9, -1, -1);
    run_op("b2b_b",       1'b0, 32'hDEAD_BEEF, 32'd17, -1, -1);

    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = $urandom_range(1, 15);
        3:       rb = 32'hFFFF_FFFF;
        4:       rb = 32'hFFFF_FFFF - $urandom_range(0, 15);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), rs, ra, rb, -1, -1);
    end

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst.busy", 64'(busy), 64'd0);
    chk("arst.done", 64'(done), 64'd0);
    chk("arst.q",    64'(quotient), 64'd0);
    chk("arst.r",    64'(remainder), 64'd0);
    chk("arst.dbz",  64'(dbz), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pq = '0; pr = '0; pdbz = 1'b0;
    @(negedge clk);
    run_op("post_rst",    1'b0, 32'd100, 32'd7, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
